// File: rtl/trng_postproc.sv
// TRNG post-processing: repetition-count health test, von Neumann debiasing, LSB-first byte packing
// and a small valid/ready byte FIFO. Define TRNG_APT_EN to add the adaptive-proportion health test.
module trng_postproc #(
   parameter int unsigned RCT_CUTOFF = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned APT_WINDOW = 512,
   parameter int unsigned APT_CUTOFF = 410
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          raw_bit,
   input  logic                          raw_valid,
   input  logic                          clear_err,
   output logic [7:0]                    out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          health_fail,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = AW + 1;
   localparam int unsigned RUN_W = 8;

   // Elaborates only for an out-of-range configuration, making it visible in the hierarchy.
   if (RCT_CUTOFF < 2 || RCT_CUTOFF > 255 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || APT_CUTOFF >= APT_WINDOW) begin : g_illegal_params
   end

   logic w_accept;
   logic w_fail_set;
   logic w_apt_hit;
   logic r_health_fail;
   logic r_overflow;

   assign w_accept = raw_valid && en;

   // ---------------- repetition-count test ----------------
   logic [RUN_W-1:0] r_run_cnt;
   logic [RUN_W-1:0] w_run_nxt;
   logic             r_last_bit;
   logic             r_rct_hit;

   always_comb begin
      w_run_nxt = r_run_cnt;
      if (r_run_cnt == '0 || raw_bit != r_last_bit)
         w_run_nxt = RUN_W'(1);
      else if (r_run_cnt != '1)
         w_run_nxt = r_run_cnt + RUN_W'(1);
   end

   // The hit is a one-cycle event so a clear_err after a long run actually clears the flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run_cnt  <= '0;
         r_last_bit <= 1'b0;
         r_rct_hit  <= 1'b0;
      end else begin
         r_rct_hit <= 1'b0;
         if (!en || clear_err) begin
            r_run_cnt <= '0;
         end else if (raw_valid) begin
            r_run_cnt  <= w_run_nxt;
            r_last_bit <= raw_bit;
            r_rct_hit  <= (w_run_nxt == RUN_W'(RCT_CUTOFF));
         end
      end
   end

   // ---------------- adaptive-proportion test ----------------
`ifdef TRNG_APT_EN
   localparam int unsigned WIN_W = $clog2(APT_WINDOW + 1);
   logic [WIN_W-1:0] r_win_cnt;
   logic [WIN_W-1:0] r_match_cnt;
   logic [WIN_W-1:0] w_match_nxt;
   logic             r_apt_ref;
   logic             r_apt_hit;

   always_comb begin
      w_match_nxt = r_match_cnt;
      if (r_win_cnt == '0)
         w_match_nxt = WIN_W'(1);
      else if (raw_bit == r_apt_ref)
         w_match_nxt = r_match_cnt + WIN_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win_cnt   <= '0;
         r_match_cnt <= '0;
         r_apt_ref   <= 1'b0;
         r_apt_hit   <= 1'b0;
      end else begin
         r_apt_hit <= 1'b0;
         if (!en || clear_err) begin
            r_win_cnt   <= '0;
            r_match_cnt <= '0;
         end else if (raw_valid) begin
            if (r_win_cnt == '0)
               r_apt_ref <= raw_bit;
            r_match_cnt <= w_match_nxt;
            r_win_cnt   <= (r_win_cnt == WIN_W'(APT_WINDOW - 1)) ? '0 : r_win_cnt + WIN_W'(1);
            r_apt_hit   <= (w_match_nxt == WIN_W'(APT_CUTOFF + 1));
         end
      end
   end

   assign w_apt_hit = r_apt_hit;
`else
   assign w_apt_hit = 1'b0;
`endif

   assign w_fail_set = r_rct_hit || w_apt_hit;

   // ---------------- von Neumann extractor ----------------
   logic r_pair_full;
   logic r_pair_bit;
   logic w_db_valid;
   logic w_db_bit;

   assign w_db_valid = w_accept && r_pair_full && (r_pair_bit != raw_bit);
   assign w_db_bit   = r_pair_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pair_full <= 1'b0;
         r_pair_bit  <= 1'b0;
      end else if (!en || w_fail_set) begin
         r_pair_full <= 1'b0;
      end else if (raw_valid) begin
         if (r_pair_full) begin
            r_pair_full <= 1'b0;
         end else begin
            r_pair_full <= 1'b1;
            r_pair_bit  <= raw_bit;
         end
      end
   end

   // ---------------- byte packer ----------------
   logic [6:0] r_shift;
   logic [2:0] r_bit_cnt;
   logic       w_pack;
   logic       w_push;
   logic [7:0] w_push_byte;

   assign w_pack      = w_db_valid && !r_health_fail && !w_fail_set;
   assign w_push      = w_pack && (r_bit_cnt == 3'd7);
   assign w_push_byte = {w_db_bit, r_shift};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (w_fail_set) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (w_pack) begin
         if (r_bit_cnt == 3'd7)
            r_shift <= '0;
         else
            r_shift[r_bit_cnt] <= w_db_bit;
         r_bit_cnt <= r_bit_cnt + 3'd1;
      end
   end

   // ---------------- byte FIFO ----------------
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             r_out_valid;
   logic [7:0]       r_out_data;
   logic             w_full;
   logic             w_pop;
   logic             w_push_ok;
   logic             w_drop;
   logic [LVL_W-1:0] w_level_nxt;
   logic [AW-1:0]    w_rd_nxt;
   logic [7:0]       w_head_nxt;

   assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_pop       = r_out_valid && out_ready;
   assign w_push_ok   = w_push && (!w_full || w_pop);
   assign w_drop      = w_push && w_full && !w_pop;
   assign w_level_nxt = r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop);
   assign w_rd_nxt    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

   // Head register: bypass the incoming byte when it becomes the only entry.
   always_comb begin
      w_head_nxt = 8'h00;
      if (w_level_nxt != '0) begin
         if (w_push_ok && w_rd_nxt == r_wr_ptr)
            w_head_nxt = w_push_byte;
         else
            w_head_nxt = r_mem[w_rd_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= w_push_byte;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= 8'h00;
      end else if (w_fail_set) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= 8'h00;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr    <= w_rd_nxt;
         r_level     <= w_level_nxt;
         r_out_valid <= (w_level_nxt != '0);
         r_out_data  <= w_head_nxt;
      end
   end

   // ---------------- sticky flags ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_health_fail <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         if (w_fail_set)
            r_health_fail <= 1'b1;
         else if (clear_err)
            r_health_fail <= 1'b0;
         if (w_drop)
            r_overflow <= 1'b1;
         else if (clear_err)
            r_overflow <= 1'b0;
      end
   end

   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign health_fail = r_health_fail;
   assign overflow    = r_overflow;
   assign fifo_level  = r_level;

endmodule

// File: tb/tb_trng_postproc.sv
// Directed self-checking bench for trng_postproc with hand-computed expected bytes and flags.
module tb_trng_postproc;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       raw_bit;
   logic       raw_valid;
   logic       clear_err;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       health_fail;
   logic       overflow;
   logic [2:0] fifo_level;

   int n_checks = 0;
   int n_fail   = 0;

   trng_postproc dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .raw_bit     (raw_bit),
      .raw_valid   (raw_valid),
      .clear_err   (clear_err),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .health_fail (health_fail),
      .overflow    (overflow),
      .fifo_level  (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic b);
      raw_bit   = b;
      raw_valid = 1'b1;
      @(posedge clk);
      #1;
      raw_valid = 1'b0;
   endtask

   task automatic send_pair(input logic [1:0] p);
      send(p[1]);
      send(p[0]);
   endtask

   // One debiased bit per pair: 10 -> 1, 01 -> 0.
   task automatic send_byte(input logic [7:0] b);
      for (int k = 0; k < 8; k++)
         send_pair(b[k] ? 2'b10 : 2'b01);
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      @(posedge clk);
      #1;
      clear_err = 1'b0;
   endtask

   logic [1:0] vec_pairs [11];
   logic [7:0] drain_exp [4];
   logic [7:0] byte_81;

   initial begin
      vec_pairs = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
      drain_exp = '{8'hFD, 8'h0F, 8'hA5, 8'h81};
      byte_81   = 8'h81;

      rst = 1'b1; en = 1'b0; raw_bit = 1'b0; raw_valid = 1'b0;
      clear_err = 1'b0; out_ready = 1'b0;
      idle(2);
      check("rst_data",  32'(out_data),    32'h0);
      check("rst_valid", 32'(out_valid),   32'h0);
      check("rst_level", 32'(fifo_level),  32'h0);
      check("rst_hf",    32'(health_fail), 32'h0);
      check("rst_ovf",   32'(overflow),    32'h0);
      rst = 1'b0;
      en  = 1'b1;

      // Debias / pack: first 8 debiased bits 1,0,1,0,0,1,1,0 -> 0x65
      for (int i = 0; i < 9; i++) send_pair(vec_pairs[i]);
      check("vn_valid_7bits", 32'(out_valid), 32'h0);
      send_pair(vec_pairs[9]);
      check("vn_valid_8bits", 32'(out_valid),  32'h1);
      check("vn_byte",        32'(out_data),   32'h65);
      check("vn_level",       32'(fifo_level), 32'h1);
      send_pair(vec_pairs[10]);
      check("vn_pending_level", 32'(fifo_level), 32'h1);

      // en gating: stored first-of-pair bit must be discarded, shifter held
      send(1'b1);
      en = 1'b0;
      for (int i = 0; i < 100; i++) begin
         raw_valid = i[0];
         raw_bit   = i[1];
         @(posedge clk);
         #1;
      end
      raw_valid = 1'b0;
      check("en0_level", 32'(fifo_level), 32'h1);
      check("en0_head",  32'(out_data),   32'h65);
      en = 1'b1;
      send_pair(2'b01);
      for (int i = 0; i < 6; i++) send_pair(2'b10);
      check("en1_level", 32'(fifo_level), 32'h2);
      check("en1_head",  32'(out_data),   32'h65);

      // Fill and overflow
      send_byte(8'h0F);
      check("fill_level3", 32'(fifo_level), 32'h3);
      send_byte(8'hA5);
      check("fill_level4", 32'(fifo_level), 32'h4);
      check("fill_ovf0",   32'(overflow),   32'h0);
      send_byte(8'h3C);
      check("ovf_level", 32'(fifo_level), 32'h4);
      check("ovf_flag",  32'(overflow),   32'h1);
      check("ovf_head",  32'(out_data),   32'h65);
      pulse_clear();
      check("ovf_cleared", 32'(overflow), 32'h0);

      // Push coinciding with pop while full
      for (int k = 0; k < 7; k++) send_pair(byte_81[k] ? 2'b10 : 2'b01);
      send(1'b1);
      raw_bit = 1'b0; raw_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      raw_valid = 1'b0; out_ready = 1'b0;
      check("pp_level", 32'(fifo_level), 32'h4);
      check("pp_ovf",   32'(overflow),   32'h0);
      check("pp_head",  32'(out_data),   32'hFD);

      // Drain in order
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain%0d", i), 32'(out_data), 32'(drain_exp[i]));
         out_ready = 1'b1;
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      check("drain_valid", 32'(out_valid),  32'h0);
      check("drain_data",  32'(out_data),   32'h0);
      check("drain_level", 32'(fifo_level), 32'h0);

      // Asynchronous reset mid-operation
      send_byte(8'hFF);
      for (int i = 0; i < 3; i++) send_pair(2'b01);
      send(1'b0);
      check("pre_rst_valid", 32'(out_valid), 32'h1);
      rst = 1'b1;
      #2;
      check("arst_data",  32'(out_data),   32'h0);
      check("arst_valid", 32'(out_valid),  32'h0);
      check("arst_level", 32'(fifo_level), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_byte(8'hFF);
      check("post_rst_byte",  32'(out_data),   32'hFF);
      check("post_rst_level", 32'(fifo_level), 32'h1);

      // RCT: 31 ones do not trip, 32 do (one edge later)
      for (int i = 0; i < 3; i++) send_pair(2'b10);
      repeat (31) send(1'b1);
      send(1'b0);
      idle(2);
      check("rct31_hf", 32'(health_fail), 32'h0);
      repeat (32) send(1'b1);
      check("rct32_hf_same", 32'(health_fail), 32'h0);
      idle(1);
      check("rct_hf",    32'(health_fail), 32'h1);
      check("rct_level", 32'(fifo_level),  32'h0);
      check("rct_valid", 32'(out_valid),   32'h0);
      check("rct_data",  32'(out_data),    32'h0);
      send_byte(8'hFF);
      check("hf_nopack_level", 32'(fifo_level), 32'h0);
      pulse_clear();
      check("clr_hf", 32'(health_fail), 32'h0);
      send_byte(8'h5A);
      check("resume_byte",  32'(out_data),   32'h5A);
      check("resume_level", 32'(fifo_level), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trng_postproc.md
Name: trng_postproc

Overview:
- Digital post-processing stage directly downstream of the ring-oscillator entropy sampler inside tt_um_wahab_trng.
- Takes sampled raw bits and runs a continuous repetition-count health test on them.
- Debiases with a von Neumann extractor, packs the result LSB-first into bytes and buffers them in a small FIFO.
- Presents the FIFO on a valid/ready byte interface that the top level maps to uo_out/uio.

Parameters:
- RCT_CUTOFF, 32: count of consecutive identical raw bits that trips the repetition-count test. Legal range 2..255.
- FIFO_DEPTH, 4: byte FIFO entries. Must be a power of two, at least 2.
- APT_WINDOW, 512: adaptive-proportion window length in raw bits. Used only with TRNG_APT_EN.
- APT_CUTOFF, 410: maximum count of ones or zeros allowed within one window. Used only with TRNG_APT_EN.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  processing enable.
- raw_bit  in  1  sampled entropy bit, already synchronised to clk.
- raw_valid  in  1  raw_bit is valid this cycle.
- clear_err  in  1  one-cycle pulse; clears sticky flags.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head byte.
- health_fail  out  1  sticky health-test failure.
- overflow  out  1  sticky: a completed byte was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release): out_data=0, out_valid=0, health_fail=0, overflow=0, fifo_level=0. Pair register, byte shifter, bit counter, RCT counter and FIFO pointers all zero.
- Accepted raw bit = cycle with raw_valid && en. With en=0, raw bits are ignored and the pair register and RCT counter are cleared. The byte shifter is held and the FIFO keeps draining.
- RCT:
  - Tracks last accepted raw bit and a run count (run starts at 1).
  - When the run count reaches RCT_CUTOFF, health_fail is set on the next edge.
  - The RCT runs whether or not health_fail is already set.
- Von Neumann extractor:
  - First accepted bit is stored and pair_full is set.
  - Second accepted bit: 01 gives debiased bit 0; 10 gives debiased bit 1; 00 or 11 is discarded. pair_full clears in all cases.
  - Pairs never overlap.
- Byte packer:
  - Debiased bit k (0..7) goes to shifter bit k, so the first bit is the LSB.
  - On the 8th bit, the byte is written to the FIFO at that same edge; out_valid is high the following cycle if the FIFO was empty.
  - Bit counter wraps 7 to 0.
- FIFO push/pop:
  - Pop occurs when out_valid && out_ready.
  - Push onto a full FIFO with a simultaneous pop succeeds; level unchanged.
  - Push onto a full FIFO without a pop is dropped and overflow is set.
  - out_data is registered head data: stable while out_valid && !out_ready. It returns to 0 when the FIFO is empty.
- Failure handling: on the edge that sets health_fail, the FIFO is flushed (level 0, out_valid 0) and the partial byte and pair register are cleared. While health_fail=1, no debiased bits are packed.
- clear_err: clears health_fail, overflow and the RCT run count in one edge. If clear_err and a new failure condition occur in the same cycle, the failure wins and health_fail stays 1.
- fifo_level saturates at FIFO_DEPTH and never wraps.

Optional Feature:
- Macro: TRNG_APT_EN.
- When defined, an adaptive-proportion test counts raw bits equal to the first bit of each APT_WINDOW-bit window.
  - If that count exceeds APT_CUTOFF, health_fail is set with the same flush semantics as the RCT.
  - The window restarts after APT_WINDOW accepted bits, on en=0, and on clear_err.
- When not defined, no APT logic is synthesised and health_fail is driven by the RCT alone.

Test Plan:
- Reset mid-operation: 3 pairs in, then rst pulse → all outputs 0 immediately, with no clk edge required. Next 16 bits of pattern 10 repeated → byte 0xFF.
- Debias/pack: raw pairs 10,01,00,10,11,01,01,10,10,01,10 (raw_valid=1, en=1, out_ready=0). Debiased bits are 1,0,1,0,0,1,1,0,1.
  - First 8 debiased bits → out_data=0x65, out_valid=1 one cycle after the 8th pair, fifo_level=1.
  - The 9th bit stays pending in the shifter.
- FIFO full: out_ready=0, push 5 bytes with FIFO_DEPTH=4 → fifo_level=4, overflow=1, head still the first byte. Then out_ready=1 → 4 bytes drain in order, then out_valid=0.
- Simultaneous push/pop at full: a byte completes in the same cycle as a pop → level stays 4, overflow stays 0.
- RCT: 32 consecutive raw 1s → health_fail=1, FIFO flushed, fifo_level=0. Then clear_err pulse → health_fail=0, and packing resumes from bit 0.
- en gating: en=0 while raw_valid toggles for 100 cycles → no change to level or shifter. A stored first-of-pair bit is discarded.
